// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: walks each instruction
// through its state sequence and drives the datapath strobes and selects.
module multicycle_control #(
  parameter int USE_MEM_READY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] UC_signal,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] RWB    = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] ADDIEX = 4'd9;
  localparam logic [3:0] ADDIWB = 4'd10;
  localparam logic [3:0] JUMP   = 4'd11;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [3:0] state_q, state_d;
  logic       memReady;

  // With the handshake disabled, memory is assumed to answer in one cycle.
  assign memReady = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
  assign state    = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = FETCH;
    PCWrite   = 1'b0;
    IorD      = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    PCSrc     = 2'b00;
    UC_signal = 3'b000;
    illegal   = 1'b0;
    case (state_q)
      FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b01;
        UC_signal = 3'b001;
        // Reset already holds state in FETCH; keep it from latching IR/PC too.
        IRWrite   = memReady & ~reset;
        PCWrite   = memReady & ~reset;
        state_d   = memReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB   = 2'b11;
        UC_signal = 3'b001;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            state_d = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        UC_signal = 3'b001;
        state_d   = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = memReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = memReady ? FETCH : MEMWR;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        state_d = RWB;
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA   = 1'b1;
        UC_signal = 3'b010;
        PCSrc     = 2'b01;
        PCWrite   = zero;
      end
      ADDIEX: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        UC_signal = 3'b001;
        state_d   = ADDIWB;
      end
      ADDIWB: RegWrite = 1'b1;
      JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: expected state/strobe vectors are
// queued when each cycle's stimulus is applied and popped at the sample point.
module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = OP_LW;
  logic       mem_ready = 1'b1;
  logic       zero = 1'b0;

  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] UC_signal;
  logic       illegal;
  logic [3:0] state;

  logic       o0PCWrite, o0IorD, o0MemRead, o0MemWrite, o0IRWrite, o0RegDst, o0MemtoReg, o0RegWrite, o0ALUSrcA;
  logic [1:0] o0ALUSrcB, o0PCSrc;
  logic [2:0] o0UC;
  logic       o0Illegal;
  logic [3:0] o0State;

  logic [16:0] ctrl;
  logic [20:0] sb[$];
  logic [3:0]  altSb[$];
  int checks = 0;
  int passes = 0;
  int fails  = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .UC_signal(UC_signal), .illegal(illegal), .state(state)
  );

  multicycle_control #(.USE_MEM_READY(0)) dut0 (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .PCWrite(o0PCWrite), .IorD(o0IorD), .MemRead(o0MemRead), .MemWrite(o0MemWrite), .IRWrite(o0IRWrite),
    .RegDst(o0RegDst), .MemtoReg(o0MemtoReg), .RegWrite(o0RegWrite), .ALUSrcA(o0ALUSrcA),
    .ALUSrcB(o0ALUSrcB), .PCSrc(o0PCSrc), .UC_signal(o0UC), .illegal(o0Illegal), .state(o0State)
  );

  assign ctrl = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                 ALUSrcB, PCSrc, UC_signal, illegal};

  always #5 clk = ~clk;

  // Reference strobe table, one row per state, same packing as ctrl.
  function automatic logic [16:0] model(input logic [3:0] s, input logic [5:0] op, input logic z,
                                        input logic mr, input logic rst);
    logic pcw, iord, mrd, mwr, irw, rdst, m2r, rw, asa, ill;
    logic [1:0] asb, pcs;
    logic [2:0] uc;
    {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, asa, ill} = '0;
    asb = 2'b00; pcs = 2'b00; uc = 3'b000;
    case (s)
      4'd0:  begin mrd = 1; asb = 2'b01; uc = 3'b001; irw = mr & ~rst; pcw = mr & ~rst; end
      4'd1:  begin asb = 2'b11; uc = 3'b001;
                   ill = !(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J}); end
      4'd2:  begin asa = 1; asb = 2'b10; uc = 3'b001; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mwr = 1; iord = 1; end
      4'd6:  begin asa = 1; end
      4'd7:  begin rw = 1; rdst = 1; end
      4'd8:  begin asa = 1; uc = 3'b010; pcs = 2'b01; pcw = z; end
      4'd9:  begin asa = 1; asb = 2'b10; uc = 3'b001; end
      4'd10: begin rw = 1; end
      4'd11: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, pcs, uc, ill};
  endfunction

  task automatic applyStimulus(input logic [5:0] op, input logic mr, input logic z, input logic [3:0] s);
    opcode    = op;
    mem_ready = mr;
    zero      = z;
    sb.push_back({s, model(s, op, z, mr, reset)});
  endtask

  task automatic checkNow(input string tag);
    logic [20:0] obs, expv;
    obs = {state, ctrl};
    checks++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL %s: observed=%h but no expected entry queued", tag, obs);
    end else begin
      expv = sb.pop_front();
      assert (obs === expv) begin
        passes++;
      end else begin
        fails++;
        $error("FAIL %s: observed state=%0d ctrl=%h expected state=%0d ctrl=%h",
               tag, obs[20:17], obs[16:0], expv[20:17], expv[16:0]);
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [3:0] expA;
    #5;
    checkNow(tag);
    if (altSb.size() > 0) begin
      expA = altSb.pop_front();
      checks++;
      assert (o0State === expA) begin
        passes++;
      end else begin
        fails++;
        $error("FAIL %s_nowait: observed state=%0d expected state=%0d", tag, o0State, expA);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runInstr(input string name, input logic [5:0] op, input logic z,
                          input logic [23:0] seq, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(op, 1'b1, z, seq[(5-i)*4 +: 4]);
      checkOutput($sformatf("%s_c%0d", name, i));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(posedge clk);
    #1;
    applyStimulus(OP_LW, 1'b1, 1'b0, 4'd0);
    checkOutput("reset_held");
    reset = 1'b0;

    runInstr("lw",    OP_LW,   1'b0, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0}, 5);
    runInstr("sw",    OP_SW,   1'b0, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0}, 4);
    runInstr("rtype", OP_R,    1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0}, 4);
    runInstr("addi",  OP_ADDI, 1'b0, {4'd0, 4'd1, 4'd9, 4'd10, 4'd0, 4'd0}, 4);
    runInstr("beq_t", OP_BEQ,  1'b1, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0, 4'd0}, 3);
    runInstr("beq_n", OP_BEQ,  1'b0, {4'd0, 4'd1, 4'd8, 4'd0, 4'd0, 4'd0}, 3);
    runInstr("jump",  OP_J,    1'b0, {4'd0, 4'd1, 4'd11, 4'd0, 4'd0, 4'd0}, 3);
    runInstr("bad",   OP_BAD,  1'b0, {4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0}, 2);

    // Store held in MEMWR for three stall cycles.
    applyStimulus(OP_SW, 1'b1, 1'b0, 4'd0); checkOutput("swst_fetch");
    applyStimulus(OP_SW, 1'b1, 1'b0, 4'd1); checkOutput("swst_decode");
    applyStimulus(OP_SW, 1'b1, 1'b0, 4'd2); checkOutput("swst_memadr");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_SW, 1'b0, 1'b0, 4'd5); checkOutput($sformatf("swst_stall%0d", i));
    end
    applyStimulus(OP_SW, 1'b1, 1'b0, 4'd5); checkOutput("swst_done");

    // Instruction fetch stalled three cycles.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_J, 1'b0, 1'b0, 4'd0); checkOutput($sformatf("fst_stall%0d", i));
    end
    applyStimulus(OP_J, 1'b1, 1'b0, 4'd0);  checkOutput("fst_ready");
    applyStimulus(OP_J, 1'b1, 1'b0, 4'd1);  checkOutput("fst_decode");
    applyStimulus(OP_J, 1'b1, 1'b0, 4'd11); checkOutput("fst_jump");

    // Load stalled in MEMRD, then aborted by an asynchronous reset pulse.
    applyStimulus(OP_LW, 1'b1, 1'b0, 4'd0); checkOutput("lwrst_fetch");
    applyStimulus(OP_LW, 1'b1, 1'b0, 4'd1); checkOutput("lwrst_decode");
    applyStimulus(OP_LW, 1'b1, 1'b0, 4'd2); checkOutput("lwrst_memadr");
    applyStimulus(OP_LW, 1'b0, 1'b0, 4'd3); checkOutput("lwrst_stall0");
    applyStimulus(OP_LW, 1'b0, 1'b0, 4'd3); checkOutput("lwrst_stall1");
    #2;
    reset = 1'b1;
    applyStimulus(OP_LW, 1'b1, 1'b0, 4'd0);
    #1;
    checkNow("rst_async");
    @(posedge clk);
    #1;
    applyStimulus(OP_LW, 1'b1, 1'b0, 4'd0);
    checkNow("rst_held_edge");
    #2;
    reset = 1'b0;
    #1;
    applyStimulus(OP_LW, 1'b1, 1'b0, 4'd0);
    checkNow("rst_release_fetch");
    @(posedge clk);
    #1;
    applyStimulus(OP_LW, 1'b1, 1'b0, 4'd1); checkOutput("rst_fresh_decode");

    // Handshake disabled: dut0 runs a full load while mem_ready stays low.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(OP_LW, 1'b0, 1'b0, 4'd0);
      altSb.push_back((i == 5) ? 4'd0 : 4'(i));
      checkOutput($sformatf("nomr_c%0d", i));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
